// File: rtl/instr_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_if
// Bundles the instruction-memory request/response bus and the decode-side
// instruction stream of the fetch queue.
//   master : the fetch queue itself
//            out: ImemReq, ImemAddr, InstrValid, Instr, PCF
//            in : ImemGnt, ImemRvalid, ImemRdata, InstrReady, Redirect, RedirectPC
//   slave  : the environment (memory + decode/branch unit), directions mirrored
// ---------------------------------------------------------------------------
interface instr_fetch_queue_if;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemGnt;
   logic        ImemRvalid;
   logic [31:0] ImemRdata;
   logic        InstrValid;
   logic [31:0] Instr;
   logic [31:0] PCF;
   logic        InstrReady;
   logic        Redirect;
   logic [31:0] RedirectPC;

   modport master (
      output ImemReq, ImemAddr, InstrValid, Instr, PCF,
      input  ImemGnt, ImemRvalid, ImemRdata, InstrReady, Redirect, RedirectPC
   );

   modport slave (
      input  ImemReq, ImemAddr, InstrValid, Instr, PCF,
      output ImemGnt, ImemRvalid, ImemRdata, InstrReady, Redirect, RedirectPC
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Instruction fetch front end: issues word-aligned reads to instruction
// memory, tracks up to two outstanding addresses, buffers up to two returned
// {PC, Instr} pairs for decode, and flushes/refetches on a redirect.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : instr_fetch_queue_if.master (memory bus + decode stream)
// Parameter:
//   RESET_PC : first fetch address after reset
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   instr_fetch_queue_if.master    bus
);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [31:0] r_fetch_pc;

   // Output FIFO: {PC, Instr} pairs awaiting decode
   logic [31:0] r_ofifo_pc    [2];
   logic [31:0] r_ofifo_instr [2];
   logic        r_ofifo_rd_ptr;
   logic        r_ofifo_wr_ptr;
   logic [1:0]  r_ofifo_cnt;

   // In-flight FIFO: granted addresses whose data has not returned yet
   logic [31:0] r_infl_addr [2];
   logic        r_infl_rd_ptr;
   logic        r_infl_wr_ptr;
   logic [1:0]  r_infl_cnt;

   // Responses still owed by memory for requests made before a redirect
   logic [1:0]  r_discard_cnt;

   logic        w_req;
   logic        w_grant;
   logic        w_rsp;
   logic        w_infl_pop;
   logic        w_push;
   logic        w_pop;
   logic [2:0]  w_outstanding;
   logic [2:0]  w_discard_redir;
   logic        w_unused;

   // Everything memory still owes us: live requests plus ones being dropped.
   // Only one of the two terms is non-zero at a time (RUN vs DRAIN).
   assign w_outstanding   = {1'b0, r_infl_cnt} + {1'b0, r_discard_cnt};
   // A response with nothing outstanding (e.g. left over from before a reset)
   // is simply ignored.
   assign w_rsp           = bus.ImemRvalid && (w_outstanding != 3'd0);
   assign w_infl_pop      = w_rsp && (r_state == ST_RUN) && (r_infl_cnt != 2'd0);
   assign w_push          = w_infl_pop && !bus.Redirect;
   assign w_pop           = (r_ofifo_cnt != 2'd0) && bus.InstrReady;
   assign w_discard_redir = w_outstanding + {2'b00, w_grant} - {2'b00, w_rsp};

   assign w_unused = &{1'b0, bus.RedirectPC[1:0], w_discard_redir[2]};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RESET;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next state and request ----------------
   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      w_grant      = 1'b0;

      // Request only when the issued-but-unconsumed total leaves room, so a
      // returning word always finds a free output slot.
      if ((r_state == ST_RUN) && !bus.Redirect &&
          (({1'b0, r_ofifo_cnt} + {1'b0, r_infl_cnt}) < 3'd2)) begin
         w_req = 1'b1;
      end
      w_grant = w_req && bus.ImemGnt;

      if (bus.Redirect) begin
         w_state_next = (w_discard_redir != 3'd0) ? ST_DRAIN : ST_RUN;
      end else begin
         case (r_state)
            ST_RESET: w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            // Leave one cycle after the last stale response was dropped
            ST_DRAIN: w_state_next = (r_discard_cnt == 2'd0) ? ST_RUN : ST_DRAIN;
            default:  w_state_next = ST_RESET;
         endcase
      end
   end

   // ---------------- fetch address ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
      end else if (bus.Redirect) begin
         r_fetch_pc <= {bus.RedirectPC[31:2], 2'b00};
      end else if (w_grant) begin
         r_fetch_pc <= r_fetch_pc + 32'd4;
      end
   end

   // ---------------- discard counter ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_discard_cnt <= 2'd0;
      end else if (bus.Redirect) begin
         r_discard_cnt <= w_discard_redir[1:0];
      end else if ((r_state == ST_DRAIN) && w_rsp && (r_discard_cnt != 2'd0)) begin
         r_discard_cnt <= r_discard_cnt - 2'd1;
      end
   end

   // ---------------- in-flight FIFO control ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_infl_rd_ptr <= 1'b0;
         r_infl_wr_ptr <= 1'b0;
         r_infl_cnt    <= 2'd0;
      end else if (bus.Redirect) begin
         // Outstanding requests are now tracked only by r_discard_cnt
         r_infl_rd_ptr <= 1'b0;
         r_infl_wr_ptr <= 1'b0;
         r_infl_cnt    <= 2'd0;
      end else begin
         if (w_grant)    r_infl_wr_ptr <= ~r_infl_wr_ptr;
         if (w_infl_pop) r_infl_rd_ptr <= ~r_infl_rd_ptr;
         r_infl_cnt <= r_infl_cnt + {1'b0, w_grant} - {1'b0, w_infl_pop};
      end
   end

   // ---------------- output FIFO control ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ofifo_rd_ptr <= 1'b0;
         r_ofifo_wr_ptr <= 1'b0;
         r_ofifo_cnt    <= 2'd0;
      end else if (bus.Redirect) begin
         // Keep the read pointer so Instr/PCF hold their value while empty
         r_ofifo_wr_ptr <= r_ofifo_rd_ptr;
         r_ofifo_cnt    <= 2'd0;
      end else begin
         if (w_push) r_ofifo_wr_ptr <= ~r_ofifo_wr_ptr;
         if (w_pop)  r_ofifo_rd_ptr <= ~r_ofifo_rd_ptr;
         r_ofifo_cnt <= r_ofifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // ---------------- FIFO storage ----------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_infl_addr[gi] <= 32'd0;
         end else if (w_grant && !bus.Redirect && (r_infl_wr_ptr == 1'(gi))) begin
            r_infl_addr[gi] <= r_fetch_pc;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_ofifo_pc[gi]    <= 32'd0;
            r_ofifo_instr[gi] <= 32'd0;
         end else if (w_push && (r_ofifo_wr_ptr == 1'(gi))) begin
            r_ofifo_pc[gi]    <= r_infl_addr[r_infl_rd_ptr];
            r_ofifo_instr[gi] <= bus.ImemRdata;
         end
      end
   end

   // ---------------- outputs ----------------
   assign bus.ImemReq    = w_req;
   assign bus.ImemAddr   = r_fetch_pc;
   assign bus.InstrValid = (r_ofifo_cnt != 2'd0);
   assign bus.Instr      = r_ofifo_instr[r_ofifo_rd_ptr];
   assign bus.PCF        = r_ofifo_pc[r_ofifo_rd_ptr];

endmodule
